// File: rtl/tt_wb_regs_pkg.sv
// Shared register offsets, reset values and byte-lane helper for the TT Wishbone register bank.
package tt_wb_regs_pkg;

  localparam logic [7:0] OFS_ID         = 8'h00;
  localparam logic [7:0] OFS_IRQ_STATUS = 8'h04;
  localparam logic [7:0] OFS_IRQ_ENABLE = 8'h08;
  localparam logic [7:0] OFS_IRQ_RAW    = 8'h0C;
  localparam logic [7:0] OFS_CTRL0      = 8'h10;

  localparam logic [31:0] RST_DATA = 32'h0000_0000;
  localparam logic [31:0] RST_CTRL = 32'h0000_0000;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  sel);
    logic [31:0] merged;
    merged = oldVal;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) merged[8*b +: 8] = newVal[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/tt_wb_regs_irq_line.sv
// One interrupt line: edge/level set detection plus a sticky status bit.
module tt_irq_line (
  input  logic clk,
  input  logic rst_n,
  input  logic i_src,
  input  logic i_mode,
  input  logic i_clr,
  output logic o_status
);

  logic r_srcQ;
  logic r_status;
  logic w_set;

  // Edge mode fires on a rising source, level mode whenever the source is high.
  assign w_set = i_mode ? (i_src & ~r_srcQ) : i_src;

  // Track source history and hold status; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_srcQ   <= 1'b0;
      r_status <= 1'b0;
    end else begin
      r_srcQ   <= i_src;
      r_status <= w_set | (r_status & ~i_clr);
    end
  end

  assign o_status = r_status;

endmodule

// File: rtl/tt_wb_regs.sv
// Wishbone classic slave: ID word, control words for tt_top and a small interrupt block.
module tt_wb_regs
  import tt_wb_regs_pkg::*;
#(
  parameter logic [31:0]      BASE_ADDR = 32'h3000_0000,
  parameter int               N_CTRL    = 4,
  parameter int               N_IRQ     = 3,
  parameter logic [N_IRQ-1:0] IRQ_EDGE  = 3'b001,
  parameter logic [31:0]      ID_VALUE  = 32'h5454_0001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_dat_i,
  input  logic [31:0]           wbs_adr_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  input  logic [N_IRQ-1:0]      irq_src_i,
  output logic [32*N_CTRL-1:0]  ctrl_o,
  output logic [N_IRQ-1:0]      user_irq
);

  localparam int CTRL0_WORD = int'(OFS_CTRL0[7:2]);

  logic              r_ack;
  logic [31:0]       r_dat;
  logic [N_IRQ-1:0]  r_enable;
  logic [N_IRQ-1:0]  r_irq;
  logic [31:0]       r_ctrl [N_CTRL];

  logic              w_hit;
  logic              w_req;
  logic              w_wr;
  logic [5:0]        w_wordIdx;
  logic [31:0]       w_clrMask;
  logic [31:0]       w_enableNew;
  logic [N_IRQ-1:0]  w_clr;
  logic [N_IRQ-1:0]  w_status;
  logic [31:0]       w_rdata;
  logic              w_unused;

  // A new request is only accepted while no ack is outstanding, giving 1,0,1,0 under a held strobe.
  assign w_hit       = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_req       = wbs_stb_i & wbs_cyc_i & w_hit & ~r_ack;
  assign w_wr        = w_req & wbs_we_i;
  assign w_wordIdx   = wbs_adr_i[7:2];
  assign w_clrMask   = byte_merge(32'h0, wbs_dat_i, wbs_sel_i);
  assign w_enableNew = byte_merge(32'(r_enable), wbs_dat_i, wbs_sel_i);
  assign w_clr       = (w_wr && (w_wordIdx == OFS_IRQ_STATUS[7:2])) ? w_clrMask[N_IRQ-1:0] : '0;
  assign w_unused    = &{1'b0, wbs_adr_i[1:0], w_enableNew, w_clrMask};

  genvar g;
  generate
    for (g = 0; g < N_IRQ; g++) begin : g_irq
      tt_irq_line u_line (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_src    (irq_src_i[g]),
        .i_mode   (IRQ_EDGE[g]),
        .i_clr    (w_clr[g]),
        .o_status (w_status[g])
      );
    end
    for (g = 0; g < N_CTRL; g++) begin : g_ctrl
      assign ctrl_o[32*g +: 32] = r_ctrl[g];
    end
  endgenerate

  // Read multiplexer; unmapped offsets return zero.
  always_comb begin
    w_rdata = RST_DATA;
    if (w_wordIdx == OFS_ID[7:2])              w_rdata = ID_VALUE;
    else if (w_wordIdx == OFS_IRQ_STATUS[7:2]) w_rdata = 32'(w_status);
    else if (w_wordIdx == OFS_IRQ_ENABLE[7:2]) w_rdata = 32'(r_enable);
    else if (w_wordIdx == OFS_IRQ_RAW[7:2])    w_rdata = 32'(irq_src_i);
    for (int i = 0; i < N_CTRL; i++) begin
      if (w_wordIdx == 6'(CTRL0_WORD + i)) w_rdata = r_ctrl[i];
    end
  end

  // Bus handshake: ack and read data are registered and present for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack <= 1'b0;
      r_dat <= RST_DATA;
    end else begin
      r_ack <= w_req;
      r_dat <= w_req ? w_rdata : RST_DATA;
    end
  end

  // Interrupt enable register and the registered interrupt outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable <= '0;
      r_irq    <= '0;
    end else begin
      if (w_wr && (w_wordIdx == OFS_IRQ_ENABLE[7:2])) r_enable <= w_enableNew[N_IRQ-1:0];
      r_irq <= w_status & r_enable;
    end
  end

  // Control words, written with byte-lane gating on the edge that raises ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CTRL; i++) r_ctrl[i] <= RST_CTRL;
    end else begin
      for (int i = 0; i < N_CTRL; i++) begin
        if (w_wr && (w_wordIdx == 6'(CTRL0_WORD + i)))
          r_ctrl[i] <= byte_merge(r_ctrl[i], wbs_dat_i, wbs_sel_i);
      end
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign user_irq  = r_irq;

endmodule

// File: tb/tb_tt_wb_regs.sv
// Directed self-checking bench for tt_wb_regs: vector table plus hand-written interrupt/reset sequences.
module tb_tt_wb_regs;

  logic         clk;
  logic         rst_n;
  logic         stb;
  logic         cyc;
  logic         we;
  logic [3:0]   sel;
  logic [31:0]  datIn;
  logic [31:0]  adr;
  logic         ack;
  logic [31:0]  datOut;
  logic [2:0]   irqSrc;
  logic [127:0] ctrlOut;
  logic [2:0]   userIrq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] expDat;
  } vec_t;

  vec_t vecs[16];

  tt_wb_regs dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (datIn),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (datOut),
    .irq_src_i (irqSrc),
    .ctrl_o    (ctrlOut),
    .user_irq  (userIrq)
  );

  // 100 MHz free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // One single-beat access: ack must appear one cycle after the strobe and drop the cycle after.
  task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [3:0] s,
                               input logic [31:0] d, output logic acked, output logic [31:0] rdata);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = wr; adr = a; sel = s; datIn = d;
    @(posedge clk); #1;
    acked = ack;
    rdata = datOut;
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    checkOutput("ackDrop", 32'(ack), 32'h0);
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input string name);
    logic        acked;
    logic [31:0] rdata;
    applyStimulus(1'b1, a, s, d, acked, rdata);
    checkOutput(name, 32'(acked), 32'h1);
  endtask

  task automatic busRead(input logic [31:0] a, input logic [31:0] expected, input string name);
    logic        acked;
    logic [31:0] rdata;
    applyStimulus(1'b0, a, 4'hF, 32'h0, acked, rdata);
    checkOutput({name, "Ack"}, 32'(acked), 32'h1);
    checkOutput(name, rdata, expected);
  endtask

  initial begin
    logic        acked;
    logic [31:0] rdata;
    logic [31:0] ackSeq [4];
    logic [31:0] datSeq [4];
    int          ackCount;

    vecs[0]  = '{1'b0, 32'h3000_0000, 4'hF, 32'h0,         32'h5454_0001};
    vecs[1]  = '{1'b1, 32'h3000_0014, 4'h5, 32'hDEAD_BEEF, 32'h0};
    vecs[2]  = '{1'b0, 32'h3000_0014, 4'hF, 32'h0,         32'h00AD_00EF};
    vecs[3]  = '{1'b0, 32'h3000_0080, 4'hF, 32'h0,         32'h0};
    vecs[4]  = '{1'b1, 32'h3000_0010, 4'hF, 32'h1234_5678, 32'h0};
    vecs[5]  = '{1'b0, 32'h3000_0010, 4'hF, 32'h0,         32'h1234_5678};
    vecs[6]  = '{1'b1, 32'h3000_001C, 4'h8, 32'hAABB_CCDD, 32'h0};
    vecs[7]  = '{1'b0, 32'h3000_001C, 4'hF, 32'h0,         32'hAA00_0000};
    vecs[8]  = '{1'b1, 32'h3000_0010, 4'h0, 32'hFFFF_FFFF, 32'h0};
    vecs[9]  = '{1'b0, 32'h3000_0010, 4'hF, 32'h0,         32'h1234_5678};
    vecs[10] = '{1'b1, 32'h3000_0084, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[11] = '{1'b0, 32'h3000_0017, 4'hF, 32'h0,         32'h00AD_00EF};
    vecs[12] = '{1'b0, 32'h3000_000C, 4'hF, 32'h0,         32'h0};
    vecs[13] = '{1'b0, 32'h3000_0008, 4'hF, 32'h0,         32'h0};
    vecs[14] = '{1'b0, 32'h3000_0004, 4'hF, 32'h0,         32'h0};
    vecs[15] = '{1'b0, 32'h3000_0018, 4'hF, 32'h0,         32'h0};

    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
    sel = 4'h0; datIn = 32'h0; adr = 32'h0; irqSrc = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("resetAck", 32'(ack), 32'h0);
    checkOutput("resetDat", datOut, 32'h0);
    checkOutput("resetCtrl0", ctrlOut[31:0], 32'h0);
    checkOutput("resetCtrl3", ctrlOut[127:96], 32'h0);
    checkOutput("resetIrq", 32'(userIrq), 32'h0);

    $display("[TB] register map vectors");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, acked, rdata);
      checkOutput($sformatf("vec%0dAck", i), 32'(acked), 32'h1);
      if (!vecs[i].we) checkOutput($sformatf("vec%0dData", i), rdata, vecs[i].expDat);
    end
    checkOutput("ctrlOut0", ctrlOut[31:0],   32'h1234_5678);
    checkOutput("ctrlOut1", ctrlOut[63:32],  32'h00AD_00EF);
    checkOutput("ctrlOut2", ctrlOut[95:64],  32'h0);
    checkOutput("ctrlOut3", ctrlOut[127:96], 32'hAA00_0000);

    $display("[TB] held strobe ack pattern");
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_0000; sel = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      ackSeq[k] = 32'(ack);
      datSeq[k] = datOut;
    end
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("heldAck%0d", k), ackSeq[k], (k % 2 == 0) ? 32'h1 : 32'h0);
      checkOutput($sformatf("heldDat%0d", k), datSeq[k], (k % 2 == 0) ? 32'h5454_0001 : 32'h0);
    end

    $display("[TB] out-of-window and abandoned accesses");
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h3000_0100; sel = 4'hF; datIn = 32'hFFFF_FFFF;
    ackCount = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ack) ackCount++;
    end
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    checkOutput("outOfWindowAcks", 32'(ackCount), 32'h0);
    checkOutput("outOfWindowCtrl0", ctrlOut[31:0], 32'h1234_5678);
    checkOutput("outOfWindowCtrl2", ctrlOut[95:64], 32'h0);

    @(negedge clk);
    stb = 1'b1; cyc = 1'b0; we = 1'b1; adr = 32'h3000_0018; sel = 4'hF; datIn = 32'h5555_5555;
    @(posedge clk); #1;
    checkOutput("noCycAck", 32'(ack), 32'h0);
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
    busRead(32'h3000_0018, 32'h0, "noCycCtrl2");

    $display("[TB] edge-mode interrupt");
    busWrite(32'h3000_0008, 4'hF, 32'h0000_0003, "enableWr");
    @(negedge clk);
    irqSrc[0] = 1'b1;
    @(posedge clk); #1;
    checkOutput("irqLatency", 32'(userIrq), 32'h0);
    @(negedge clk);
    irqSrc[0] = 1'b0;
    @(posedge clk); #1;
    checkOutput("irqEdgeOut", 32'(userIrq), 32'h1);
    busRead(32'h3000_0004, 32'h1, "statusEdge");

    irqSrc[0] = 1'b1;
    busWrite(32'h3000_0004, 4'hF, 32'h0000_0001, "w1cRaceWr");
    checkOutput("w1cRaceIrq", 32'(userIrq), 32'h1);
    busRead(32'h3000_0004, 32'h1, "w1cRaceStatus");
    busWrite(32'h3000_0004, 4'hF, 32'h0000_0001, "w1cAloneWr");
    checkOutput("w1cAloneIrq", 32'(userIrq), 32'h0);
    busRead(32'h3000_0004, 32'h0, "w1cAloneStatus");
    irqSrc[0] = 1'b0;

    $display("[TB] level-mode interrupt");
    irqSrc[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("levelIrq", 32'(userIrq), 32'h2);
    busRead(32'h3000_000C, 32'h2, "rawLevel");
    busWrite(32'h3000_0004, 4'hF, 32'h0000_0002, "levelW1cWr");
    busRead(32'h3000_0004, 32'h2, "levelResets");
    busWrite(32'h3000_0008, 4'hF, 32'h0000_0000, "disableWr");
    checkOutput("disabledIrq", 32'(userIrq), 32'h0);
    busRead(32'h3000_0004, 32'h2, "disabledStatus");
    irqSrc[1] = 1'b0;
    busWrite(32'h3000_0004, 4'hF, 32'h0000_0002, "levelDropW1c");
    busRead(32'h3000_0004, 32'h0, "levelCleared");

    $display("[TB] reset during ack cycle");
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h3000_0010; sel = 4'hF; datIn = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    checkOutput("preResetAck", 32'(ack), 32'h1);
    checkOutput("preResetCtrl0", ctrlOut[31:0], 32'hFFFF_FFFF);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncAck", 32'(ack), 32'h0);
    checkOutput("asyncDat", datOut, 32'h0);
    checkOutput("asyncCtrl0", ctrlOut[31:0], 32'h0);
    checkOutput("asyncCtrl1", ctrlOut[63:32], 32'h0);
    checkOutput("asyncIrq", 32'(userIrq), 32'h0);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("postResetAck", 32'(ack), 32'h0);
    busRead(32'h3000_0010, 32'h0, "postResetCtrl0");
    busRead(32'h3000_0014, 32'h0, "postResetCtrl1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_wb_regs.md
Name: tt_wb_regs

Overview:
- Wishbone classic slave register bank for the TT top-level wrapper.
- Replaces the constant tie-offs on the Caravel Wishbone port and user_irq lines.
- Provides an ID word, N_CTRL read/write control words driven into tt_top, and N_IRQ interrupt lines with per-line status, enable and edge/level mode.
- Sits between the Caravel management-SoC Wishbone bus and tt_top, in the user clock domain (clk = wb_clk_i).

Parameters:
- BASE_ADDR, 32'h3000_0000, bus base address; a decode matches when wbs_adr_i[31:8] == BASE_ADDR[31:8].
- N_CTRL, 4, number of 32-bit RW control registers; range 1..48.
- N_IRQ, 3, number of interrupt lines; range 1..32.
- IRQ_EDGE, 3'b001, per-line mode; 1 = rising-edge capture, 0 = level.
- ID_VALUE, 32'h5454_0001, constant returned by the ID register.

Ports:
- clk  in  1  bus and register clock.
- rst_n  in  1  asynchronous active-low reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte-lane select.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- irq_src_i  in  N_IRQ  interrupt sources; synchronous to clk.
- ctrl_o  out  32*N_CTRL  control words; word i is bits [32i+31:32i].
- user_irq  out  N_IRQ  interrupt outputs to the SoC.

Behaviour:
- Reset (asynchronous, rst_n low):
  - wbs_ack_o=0, wbs_dat_o=0, ctrl_o=0, user_irq=0.
  - IRQ_STATUS=0, IRQ_ENABLE=0, edge-detect history=0.
- Register map (byte offset = wbs_adr_i[7:0], word aligned; wbs_adr_i[1:0] ignored):
  - 0x00 ID: RO, reads ID_VALUE.
  - 0x04 IRQ_STATUS: bits [N_IRQ-1:0], W1C.
  - 0x08 IRQ_ENABLE: bits [N_IRQ-1:0], RW.
  - 0x0C IRQ_RAW: RO, current irq_src_i.
  - 0x10+4i CTRL[i]: RW for i < N_CTRL.
  - Unused bits read 0.
- Handshake:
  - A request is valid when stb & cyc & address decode.
  - wbs_ack_o asserts exactly one cycle after the request is first seen, for one cycle only.
  - Fixed latency of 1; no back-to-back acks. A strobe held through the ack cycle is a new request only after ack has dropped, so the ack pattern is 1,0,1,0.
- Reads: wbs_dat_o is registered and valid in the ack cycle. It is 0 in all other cycles.
- Writes:
  - Take effect at the clock edge that raises ack.
  - Byte lanes are gated by wbs_sel_i; sel=0 writes nothing but is still acked.
  - ctrl_o updates on that same edge.
- Unmapped offset inside the decode window: acked, reads 0, writes ignored.
- Address outside the window: no ack, no state change.
- Deassertion of cyc mid-request (before ack): the pending access is abandoned and no ack issues. A write applied on the ack edge stays applied.
- Interrupts:
  - Per-line set condition: edge mode = irq_src_i rising (src & ~src_q); level mode = src high.
  - When a set condition and a W1C on the same bit coincide, set wins.
  - In level mode, a held source re-sets the bit on the next cycle after a clear.
  - user_irq = IRQ_STATUS & IRQ_ENABLE, registered; one cycle after status changes.
  - Disabling a line does not clear its status bit.
- Reset asserted mid-transaction: all state clears immediately. No ack is produced for the interrupted access.

Decomposition:
- Package tt_wb_regs_pkg:
  - Offset constants OFS_ID, OFS_IRQ_STATUS, OFS_IRQ_ENABLE, OFS_IRQ_RAW, OFS_CTRL0.
  - Reset values.
  - Function byte_merge(old, new, sel).
- Sub-module tt_irq_line: one instance per line (generate loop).
  - Holds the edge/level detect flop and the status bit, with set-wins-over-clear priority.
  - Inputs: src, mode, clr; output: status.

Test Plan:
- Reset then read 0x3000_0000 -> ack exactly 1 cycle after strobe, dat=0x5454_0001; ctrl_o=0, user_irq=0.
- Write 0xDEAD_BEEF to 0x3000_0014 with sel=4'b0101 -> CTRL[1]=0x00AD_00EF, readback matches, ack pattern 1,0,1,0 under continuous strobe.
- Read 0x3000_0080 (unmapped) -> acked, dat=0. Access to 0x3000_0100 -> no ack for 8 cycles, ctrl_o unchanged.
- Set IRQ_ENABLE=3'b011 and pulse irq_src_i[0] for one cycle -> STATUS[0]=1, user_irq[0]=1 one cycle later.
  - W1C 0x1 coinciding with a new rising edge -> STATUS[0] stays 1.
  - W1C alone -> user_irq[0]=0.
- Hold irq_src_i[1] high (level mode) and W1C bit1 -> STATUS[1] reads 1 again. Drop the source then W1C -> reads 0.
- Start a write, pull rst_n low in the ack cycle -> all outputs 0 asynchronously, CTRL=0 after release.
